// File: rtl/mlp_sample_sequencer_if.sv
// Purpose: stimulus/control bundle between the sample sequencer and its environment.
// Latency: none (wires only).
// Backpressure: none; the sequencer streams samples with no ready input.
interface mlp_sample_sequencer_if #(
  parameter int SFP_W = 16
);
  // control pulses and function select
  logic                  start;
  logic                  retrain;
  logic [1:0]            func_sel;
  // asynchronous board switches
  logic                  sw_a;
  logic                  sw_b;
  // stimulus towards the MLP core
  logic [1:0][SFP_W-1:0] values;
  logic [0:0][SFP_W-1:0] expected;
  logic                  training;
  logic                  sample_strobe;
  logic [15:0]           epoch;
  logic                  train_done;

  // the sequencer drives the stimulus
  modport master (
    input  start, retrain, func_sel, sw_a, sw_b,
    output values, expected, training, sample_strobe, epoch, train_done
  );

  // the environment / consumer side
  modport slave (
    output start, retrain, func_sel, sw_a, sw_b,
    input  values, expected, training, sample_strobe, epoch, train_done
  );
endinterface

// File: rtl/mlp_sample_sequencer.sv
// Purpose: replays a 2-input boolean truth table for MLP training, then drives values from board switches.
// Latency: outputs registered; sample 0 one cycle after TRAIN entry; switch->values 3 clk (3+DEBOUNCE_CYCLES with MLP_SEQ_DEBOUNCE_EN).
// Backpressure: none; each sample is held for HOLD_CYCLES regardless of the consumer.
module mlp_sample_sequencer #(
  parameter int SFP_W           = 16,
  parameter int SFP_FRAC        = 8,
  parameter int HOLD_CYCLES     = 4,
  parameter int EPOCHS          = 10,
  parameter bit AUTO_START      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mlp_sample_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_INFER} state_t;
  typedef logic [1:0][SFP_W-1:0] pair_t;

  localparam logic [SFP_W-1:0] ONE       = SFP_W'(1 << SFP_FRAC);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0]      EPOCH_MAX = 16'(EPOCHS);

  // Training sample idx encodes (a,b) = (idx[1], idx[0]); values[0]=a, values[1]=b.
  function automatic pair_t sample_values(input logic [1:0] idx);
    pair_t v;
    v[0] = idx[1] ? ONE : '0;
    v[1] = idx[0] ? ONE : '0;
    return v;
  endfunction

  function automatic logic [SFP_W-1:0] target(input logic [1:0] f, input logic [1:0] idx);
    logic a, b, r;
    a = idx[1];
    b = idx[0];
    case (f)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r ? ONE : '0;
  endfunction

  // ---------------------------------------------------------------- switches
  // bit 0 = sw_a, bit 1 = sw_b
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] sw_lvl;

  // two-flop synchronizer inputs
  always_comb begin
    meta_d = {bus.sw_b, bus.sw_a};
    sync_d = meta_q;
  end

  // synchronizer flops, always running
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef MLP_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           db_lvl_q, db_lvl_d;

  // accept a new level only after DEBOUNCE_CYCLES consecutive cycles at it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      db_lvl_d[i] = db_lvl_q[i];
      if (sync_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // debounce counters and accepted levels
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_lvl_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign sw_lvl = db_lvl_q;
`else
  assign sw_lvl = sync_q;
`endif

  pair_t sw_values;
  always_comb begin
    sw_values[0] = sw_lvl[0] ? ONE : '0;
    sw_values[1] = sw_lvl[1] ? ONE : '0;
  end

  // ---------------------------------------------------------------- sequencer
  // Counters describe the sample currently on the outputs.
  state_t           state_q, state_d;
  logic [1:0]       func_q, func_d;
  logic [1:0]       sample_idx_q, sample_idx_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [15:0]      epoch_q, epoch_d;
  logic             done_q, done_d;
  logic             training_q, training_d;
  logic             strobe_q, strobe_d;
  pair_t            values_q, values_d;
  logic [SFP_W-1:0] expected_q, expected_d;
  logic             enter_train;

  // next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    sample_idx_d = sample_idx_q;
    hold_cnt_d   = hold_cnt_q;
    epoch_d      = epoch_q;
    done_d       = done_q;
    training_d   = training_q;
    strobe_d     = 1'b0;
    values_d     = values_q;
    expected_d   = expected_q;
    enter_train  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (AUTO_START || bus.start) enter_train = 1'b1;
      end
      S_TRAIN: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (sample_idx_q == 2'd3 && epoch_q == EPOCH_MAX) begin
            state_d    = S_INFER;
            training_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            sample_idx_d = sample_idx_q + 2'd1;
            hold_cnt_d   = '0;
            strobe_d     = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
        if (state_d == S_TRAIN) begin
          values_d   = sample_values(sample_idx_d);
          expected_d = target(func_q, sample_idx_d);
          // the epoch count is visible on the final hold cycle of sample 3
          if (sample_idx_d == 2'd3 && hold_cnt_d == HOLD_LAST && epoch_q != EPOCH_MAX) begin
            epoch_d = epoch_q + 16'd1;
          end
        end else begin
          values_d = sw_values;
        end
      end
      S_INFER: begin
        values_d = sw_values;
        if (bus.retrain) enter_train = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_train) begin
      state_d      = S_TRAIN;
      func_d       = bus.func_sel;
      sample_idx_d = '0;
      hold_cnt_d   = '0;
      epoch_d      = '0;
      done_d       = 1'b0;
      training_d   = 1'b1;
      strobe_d     = 1'b1;
      values_d     = sample_values(2'd0);
      expected_d   = target(bus.func_sel, 2'd0);
    end
  end

  // sequencer state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      func_q       <= '0;
      sample_idx_q <= '0;
      hold_cnt_q   <= '0;
      epoch_q      <= '0;
      done_q       <= 1'b0;
      training_q   <= 1'b0;
      strobe_q     <= 1'b0;
      values_q     <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      sample_idx_q <= sample_idx_d;
      hold_cnt_q   <= hold_cnt_d;
      epoch_q      <= epoch_d;
      done_q       <= done_d;
      training_q   <= training_d;
      strobe_q     <= strobe_d;
      values_q     <= values_d;
      expected_q   <= expected_d;
    end
  end

  assign bus.values        = values_q;
  assign bus.expected[0]   = expected_q;
  assign bus.training      = training_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.epoch         = epoch_q;
  assign bus.train_done    = done_q;

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Purpose: directed self-checking bench for mlp_sample_sequencer (two instances: auto-start and manual-start).
// Latency: cycle 0 is the first cycle after reset; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_mlp_sample_sequencer;
  localparam int         W   = 16;
  localparam logic [W-1:0] ONE = 16'h0100;
`ifdef MLP_SEQ_DEBOUNCE_EN
  localparam int SW_LAT = 3 + 16;
`else
  localparam int SW_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mlp_sample_sequencer_if #(.SFP_W(W)) ia ();
  mlp_sample_sequencer_if #(.SFP_W(W)) ib ();

  mlp_sample_sequencer #(
    .SFP_W(W), .SFP_FRAC(8), .HOLD_CYCLES(4), .EPOCHS(2),
    .AUTO_START(1'b1), .DEBOUNCE_CYCLES(16)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.master));

  mlp_sample_sequencer #(
    .SFP_W(W), .SFP_FRAC(8), .HOLD_CYCLES(2), .EPOCHS(1),
    .AUTO_START(1'b0), .DEBOUNCE_CYCLES(16)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // truth table per function; bit s is the output for sample s
  function automatic logic [3:0] truth(input int f);
    case (f)
      0:       return 4'b1000;
      1:       return 4'b1110;
      2:       return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  // expected outputs of instance A (HOLD=4, EPOCHS=2) at training cycle c (1..32)
  task automatic check_a_train(input int c, input int f);
    int         s;
    logic [3:0] t;
    logic [W-1:0] e;
    int         ep;
    s  = ((c - 1) / 4) % 4;
    t  = truth(f);
    e  = t[s] ? ONE : '0;
    ep = (c >= 32) ? 2 : (c >= 16) ? 1 : 0;
    check_eq($sformatf("a c%0d strobe", c), 32'(ia.sample_strobe), 32'(((c - 1) % 4) == 0));
    check_eq($sformatf("a c%0d training", c), 32'(ia.training), 32'd1);
    check_eq($sformatf("a c%0d done", c), 32'(ia.train_done), 32'd0);
    check_eq($sformatf("a c%0d epoch", c), 32'(ia.epoch), 32'(ep));
    check_eq($sformatf("a c%0d values0", c), 32'(ia.values[0]), 32'((s >= 2) ? ONE : 16'h0));
    check_eq($sformatf("a c%0d values1", c), 32'(ia.values[1]), 32'((s % 2 == 1) ? ONE : 16'h0));
    check_eq($sformatf("a c%0d expected", c), 32'(ia.expected[0]), 32'(e));
  endtask

  task automatic check_a_zero(input string tag);
    check_eq({tag, " values0"}, 32'(ia.values[0]), 32'd0);
    check_eq({tag, " values1"}, 32'(ia.values[1]), 32'd0);
    check_eq({tag, " expected"}, 32'(ia.expected[0]), 32'd0);
    check_eq({tag, " training"}, 32'(ia.training), 32'd0);
    check_eq({tag, " strobe"}, 32'(ia.sample_strobe), 32'd0);
    check_eq({tag, " epoch"}, 32'(ia.epoch), 32'd0);
    check_eq({tag, " done"}, 32'(ia.train_done), 32'd0);
  endtask

  initial begin
    int t;
    ia.start = 1'b0; ia.retrain = 1'b0; ia.func_sel = 2'd0; ia.sw_a = 1'b0; ia.sw_b = 1'b0;
    ib.start = 1'b0; ib.retrain = 1'b0; ib.func_sel = 2'd1; ib.sw_a = 1'b0; ib.sw_b = 1'b0;

    // ---- AND, auto start, full training run into INFER
    do_reset();
    check_a_zero("a reset");
    check_eq("b reset training", 32'(ib.training), 32'd0);
    for (int c = 1; c <= 32; c++) begin
      step();
      check_a_train(c, 0);
    end
    step();
    check_eq("a infer training", 32'(ia.training), 32'd0);
    check_eq("a infer done", 32'(ia.train_done), 32'd1);
    check_eq("a infer epoch", 32'(ia.epoch), 32'd2);
    check_eq("a infer expected held", 32'(ia.expected[0]), 32'(ONE));
    check_eq("a infer values0", 32'(ia.values[0]), 32'd0);
    check_eq("a infer strobe", 32'(ia.sample_strobe), 32'd0);
    check_eq("b idle without start", 32'(ib.training), 32'd0);

    // ---- switch path latency in INFER
    ia.sw_a = 1'b1;
    t = cyc;
    repeat (SW_LAT - 1) step();
    check_eq($sformatf("sw_a t+%0d", cyc - t), 32'(ia.values[0]), 32'd0);
    step();
    check_eq($sformatf("sw_a t+%0d", cyc - t), 32'(ia.values[0]), 32'(ONE));
    check_eq("sw_a values1 stays", 32'(ia.values[1]), 32'd0);

`ifdef MLP_SEQ_DEBOUNCE_EN
    // bouncing switch never passes the debounce window
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) ia.sw_b = ~ia.sw_b;
      step();
      check_eq($sformatf("bounce i%0d values1", i), 32'(ia.values[1]), 32'd0);
    end
    ia.sw_b = 1'b1;
    t = cyc;
    repeat (SW_LAT - 1) step();
    check_eq("debounce edge+18", 32'(ia.values[1]), 32'd0);
    step();
    check_eq("debounce edge+19", 32'(ia.values[1]), 32'(ONE));
`endif

    // ---- start ignored in INFER, retrain re-enters TRAIN with new function
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    check_eq("a start in infer ignored", 32'(ia.training), 32'd0);
    ia.sw_a = 1'b0;
    ia.func_sel = 2'd3;
    ia.retrain = 1'b1;
    step();
    ia.retrain = 1'b0;
    check_eq("a retrain training", 32'(ia.training), 32'd1);
    check_eq("a retrain strobe", 32'(ia.sample_strobe), 32'd1);
    check_eq("a retrain epoch", 32'(ia.epoch), 32'd0);
    check_eq("a retrain done", 32'(ia.train_done), 32'd0);
    check_eq("a retrain values0", 32'(ia.values[0]), 32'd0);
    check_eq("a retrain expected nand", 32'(ia.expected[0]), 32'(ONE));

    // ---- XOR, func_sel changed mid-training has no effect
    ia.func_sel = 2'd2;
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      step();
      check_a_train(c, 2);
      if (c == 10) ia.func_sel = 2'd0;
    end

    // ---- NAND, reset at epoch 1 sample 2
    ia.func_sel = 2'd3;
    do_reset();
    for (int c = 1; c <= 26; c++) step();
    check_a_train(26, 3);
    rst = 1'b1;
    step();
    check_a_zero("a mid reset");
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      check_a_train(c, 3);
    end

    // ---- instance B: manual start, HOLD=2, EPOCHS=1, OR
    ib.func_sel = 2'd1;
    do_reset();
    repeat (3) step();
    check_eq("b idle training", 32'(ib.training), 32'd0);
    check_eq("b idle strobe", 32'(ib.sample_strobe), 32'd0);
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    check_eq("b start training", 32'(ib.training), 32'd1);
    check_eq("b start strobe", 32'(ib.sample_strobe), 32'd1);
    check_eq("b s0 expected", 32'(ib.expected[0]), 32'd0);
    step();
    check_eq("b hold2 strobe", 32'(ib.sample_strobe), 32'd0);
    step();
    check_eq("b s1 strobe", 32'(ib.sample_strobe), 32'd1);
    check_eq("b s1 values1", 32'(ib.values[1]), 32'(ONE));
    check_eq("b s1 expected", 32'(ib.expected[0]), 32'(ONE));
    repeat (5) step();
    check_eq("b last hold epoch", 32'(ib.epoch), 32'd1);
    check_eq("b last hold training", 32'(ib.training), 32'd1);
    step();
    check_eq("b infer training", 32'(ib.training), 32'd0);
    check_eq("b infer done", 32'(ib.train_done), 32'd1);
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    check_eq("b start in infer ignored", 32'(ib.training), 32'd0);
    ib.func_sel = 2'd3;
    ib.start = 1'b1;
    ib.retrain = 1'b1;
    step();
    ib.start = 1'b0;
    ib.retrain = 1'b0;
    check_eq("b retrain+start training", 32'(ib.training), 32'd1);
    check_eq("b retrain+start strobe", 32'(ib.sample_strobe), 32'd1);
    check_eq("b retrain+start epoch", 32'(ib.epoch), 32'd0);
    check_eq("b retrain+start done", 32'(ib.train_done), 32'd0);
    check_eq("b retrain+start expected", 32'(ib.expected[0]), 32'(ONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
